// File: rtl/merge_pkg.sv
// Shared types and constants for the three-path result merger.
// Path numbering follows the priority order: lower path index wins.
package merge_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_PATHS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2,
    ACK_UP  = 2'd3
  } state_t;

  typedef logic [1:0] path_t;

  localparam path_t PATH_NONE = 2'd0;
  localparam path_t PATH_BJ   = 2'd1;
  localparam path_t PATH_LS   = 2'd2;
  localparam path_t PATH_ALU  = 2'd3;

  // Bit k-1 of a request vector belongs to path k.
  function automatic path_t pick_path(input logic [NUM_PATHS-1:0] req);
    path_t p;
    p = PATH_NONE;
    if (req[0])      p = PATH_BJ;
    else if (req[1]) p = PATH_LS;
    else if (req[2]) p = PATH_ALU;
    return p;
  endfunction

  function automatic logic [NUM_PATHS-1:0] path_onehot(input path_t p);
    logic [NUM_PATHS-1:0] v;
    case (p)
      PATH_BJ:  v = 3'b001;
      PATH_LS:  v = 3'b010;
      PATH_ALU: v = 3'b100;
      default:  v = 3'b000;
    endcase
    return v;
  endfunction

  function automatic logic multi_req(input logic [NUM_PATHS-1:0] req);
    return (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Output is the last stage; all stages clear on reset.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  // NOTE: state is updated with <= so every stage samples the pre-edge value
  // of its neighbour; blocking assignment here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/merge_3.sv
// Merges three 4-phase result producers into one 4-phase writeback channel.
// One transaction in flight at a time; fixed priority branch > load/store > ALU.
module merge_3
  import merge_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req_in_1,
  input  logic                 req_in_2,
  input  logic                 req_in_3,
  input  logic [WIDTH-1:0]     data_in_1,
  input  logic [WIDTH-1:0]     data_in_2,
  input  logic [WIDTH-1:0]     data_in_3,
  input  logic [REG_IDX_W-1:0] rd_in_1,
  input  logic [REG_IDX_W-1:0] rd_in_2,
  input  logic [REG_IDX_W-1:0] rd_in_3,
  input  logic                 we_in_1,
  input  logic                 we_in_2,
  input  logic                 we_in_3,
  output logic                 ack_out_1,
  output logic                 ack_out_2,
  output logic                 ack_out_3,

  output logic                 req_out,
  output logic [WIDTH-1:0]     data_out,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic                 we_out,
  input  logic                 ack_in,

  output logic                 collision
);

  logic [NUM_PATHS-1:0] req_s;
  logic                 ack_s;

  state_t               state_q;
  state_t               state_d;
  path_t                sel_q;
  path_t                grant;

  logic                 load;
  logic                 req_out_d;
  logic                 collision_d;
  logic [NUM_PATHS-1:0] ack_q;
  logic [NUM_PATHS-1:0] ack_d;
  logic                 sel_req_low;

  logic [WIDTH-1:0]     data_mux;
  logic [REG_IDX_W-1:0] rd_mux;
  logic                 we_mux;

  // ---------------------------------------------------------------------------
  // Synchronizers: the FSM never looks at a raw asynchronous input.
  // ---------------------------------------------------------------------------
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_req_bj (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in_1),
    .q     (req_s[0])
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_req_ls (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in_2),
    .q     (req_s[1])
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_req_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in_3),
    .q     (req_s[2])
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_s)
  );

  // ---------------------------------------------------------------------------
  // Arbitration and bundle selection
  // ---------------------------------------------------------------------------
  assign grant       = pick_path(req_s);
  assign sel_req_low = ((req_s & path_onehot(sel_q)) == '0);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    data_mux = '0;
    rd_mux   = '0;
    we_mux   = 1'b0;
    case (grant)
      PATH_BJ: begin
        data_mux = data_in_1;
        rd_mux   = rd_in_1;
        we_mux   = we_in_1;
      end
      PATH_LS: begin
        data_mux = data_in_2;
        rd_mux   = rd_in_2;
        we_mux   = we_in_2;
      end
      PATH_ALU: begin
        data_mux = data_in_3;
        rd_mux   = rd_in_3;
        we_mux   = we_in_3;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != PATH_NONE) state_d = SEND;
      SEND:    if (ack_s)              state_d = RELEASE;
      RELEASE: if (!ack_s)             state_d = ACK_UP;
      ACK_UP:  if (sel_req_low)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next-output logic. Results are registered below so no input ever
  // reaches an output combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    load        = 1'b0;
    req_out_d   = req_out;
    ack_d       = ack_q;
    collision_d = collision;
    case (state_q)
      IDLE: begin
        if (grant != PATH_NONE) begin
          load      = 1'b1;
          req_out_d = 1'b1;
          if (multi_req(req_s)) collision_d = 1'b1;
        end
      end
      SEND: begin
        if (ack_s) req_out_d = 1'b0;
      end
      RELEASE: begin
        if (!ack_s) ack_d = path_onehot(sel_q);
      end
      ACK_UP: begin
        if (sel_req_low) ack_d = '0;
      end
      default: begin
        req_out_d = 1'b0;
        ack_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and bundle registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_out   <= 1'b0;
      ack_q     <= '0;
      collision <= 1'b0;
    end else begin
      req_out   <= req_out_d;
      ack_q     <= ack_d;
      collision <= collision_d;
    end
  end

  // NOTE: the captured bundle is reset as well, so an abandoned transaction
  // never leaves stale data visible on data_out/rd_out/we_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= PATH_NONE;
      data_out <= '0;
      rd_out   <= '0;
      we_out   <= 1'b0;
    end else if (load) begin
      sel_q    <= grant;
      data_out <= data_mux;
      rd_out   <= rd_mux;
      we_out   <= we_mux;
    end
  end

  assign ack_out_1 = ack_q[0];
  assign ack_out_2 = ack_q[1];
  assign ack_out_3 = ack_q[2];

endmodule

// File: tb/tb_merge_3.sv
// Self-checking bench for merge_3: the bench plays all three producers and the
// writeback consumer, predicting service order from a pending-request model.
module tb_merge_3;

  localparam int W = 32;

  typedef struct {
    int         path;
    logic [W-1:0] data;
    logic [4:0] rd;
    logic       we;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_in_1 = 1'b0, req_in_2 = 1'b0, req_in_3 = 1'b0;
  logic [W-1:0] data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
  logic [4:0]   rd_in_1 = '0, rd_in_2 = '0, rd_in_3 = '0;
  logic         we_in_1 = 1'b0, we_in_2 = 1'b0, we_in_3 = 1'b0;
  logic         ack_out_1, ack_out_2, ack_out_3;
  logic         req_out;
  logic [W-1:0] data_out;
  logic [4:0]   rd_out;
  logic         we_out;
  logic         ack_in = 1'b0;
  logic         collision;
  logic [2:0]   ack_vec;

  int total = 0;
  int bad = 0;
  int cur_path = 0;

  merge_3 #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in_1  (req_in_1),
    .req_in_2  (req_in_2),
    .req_in_3  (req_in_3),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_in_3 (data_in_3),
    .rd_in_1   (rd_in_1),
    .rd_in_2   (rd_in_2),
    .rd_in_3   (rd_in_3),
    .we_in_1   (we_in_1),
    .we_in_2   (we_in_2),
    .we_in_3   (we_in_3),
    .ack_out_1 (ack_out_1),
    .ack_out_2 (ack_out_2),
    .ack_out_3 (ack_out_3),
    .req_out   (req_out),
    .data_out  (data_out),
    .rd_out    (rd_out),
    .we_out    (we_out),
    .ack_in    (ack_in),
    .collision (collision)
  );

  always #5 clk = ~clk;

  assign ack_vec = {ack_out_3, ack_out_2, ack_out_1};

  function automatic logic [2:0] onehot(input int p);
    logic [2:0] r;
    r = 3'b000;
    if (p >= 1 && p <= 3) r[p-1] = 1'b1;
    return r;
  endfunction

  // Continuous protocol watch: only the path being served may be acked, and
  // req_out must never overlap an acknowledge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (ack_vec !== 3'b000 && ack_vec !== onehot(cur_path)) begin
        bad++;
        $display("FAIL ack_select: ack_out=%b allowed=%b", ack_vec, onehot(cur_path));
      end
      total++;
      if (req_out === 1'b1 && ack_vec !== 3'b000) begin
        bad++;
        $display("FAIL req_ack_overlap: req_out=%b ack_out=%b expected no overlap", req_out, ack_vec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_req(input txn_t t);
    case (t.path)
      1: begin data_in_1 = t.data; rd_in_1 = t.rd; we_in_1 = t.we; req_in_1 = 1'b1; end
      2: begin data_in_2 = t.data; rd_in_2 = t.rd; we_in_2 = t.we; req_in_2 = 1'b1; end
      3: begin data_in_3 = t.data; rd_in_3 = t.rd; we_in_3 = t.we; req_in_3 = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic drop_req(input int p);
    case (p)
      1: req_in_1 = 1'b0;
      2: req_in_2 = 1'b0;
      3: req_in_3 = 1'b0;
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ack_in = 1'b0;
    req_in_1 = 1'b0; req_in_2 = 1'b0; req_in_3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Acts as writeback for one transaction and as producer t.path for its
  // acknowledge phase; expects t to be the transaction the merger picks.
  task automatic serve(input txn_t t, input int hold, input string tag);
    bit ok;
    cur_path = t.path;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_out === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s req_rise: req_out=%b expected 1 within 40 cycles", tag, req_out);
      drop_req(t.path);
      cur_path = 0;
      return;
    end
    total++;
    if (data_out !== t.data || rd_out !== t.rd || we_out !== t.we) begin
      bad++;
      $display("FAIL %s bundle: got data=%h rd=%0d we=%b expected data=%h rd=%0d we=%b",
               tag, data_out, rd_out, we_out, t.data, t.rd, t.we);
    end

    @(posedge clk); #1 ack_in = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_out === 1'b0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s req_fall: req_out=%b expected 0 after ack_in", tag, req_out);
    end

    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      total++;
      if (ack_vec !== 3'b000 || data_out !== t.data) begin
        bad++;
        $display("FAIL %s ack_hold: ack_out=%b data=%h expected ack_out=000 data=%h",
                 tag, ack_vec, data_out, t.data);
      end
    end
    @(posedge clk); #1 ack_in = 1'b0;

    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack_vec === onehot(t.path)) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s ack_rise: ack_out=%b expected %b", tag, ack_vec, onehot(t.path));
    end
    total++;
    if (data_out !== t.data || rd_out !== t.rd || we_out !== t.we) begin
      bad++;
      $display("FAIL %s bundle_held: got data=%h rd=%0d expected data=%h rd=%0d",
               tag, data_out, rd_out, t.data, t.rd);
    end

    @(posedge clk); #1 drop_req(t.path);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack_vec === 3'b000) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s ack_fall: ack_out=%b expected 000", tag, ack_vec);
    end
    cur_path = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({req_out, ack_vec, data_out, rd_out, we_out, collision} !== '0) begin
      bad++;
      $display("FAIL reset_values: req=%b ack=%b data=%h rd=%0d we=%b coll=%b expected all 0",
               req_out, ack_vec, data_out, rd_out, we_out, collision);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (req_out !== 1'b0 || ack_vec !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: req_out=%b ack_out=%b expected 0 and 000", req_out, ack_vec);
    end
  endtask

  task automatic test_single_alu();
    txn_t t;
    t = '{path: 3, data: 32'h0000_00A5, rd: 5'd7, we: 1'b1};
    @(posedge clk); #1 drive_req(t);
    repeat (3) @(negedge clk);
    total++;
    if (req_out !== 1'b0) begin
      bad++;
      $display("FAIL single_latency_early: req_out=%b expected 0 after 2 edges", req_out);
    end
    @(negedge clk);
    total++;
    if (req_out !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: req_out=%b expected 1 after 3 edges", req_out);
    end
    serve(t, 1, "single_alu");
    total++;
    if (collision !== 1'b0) begin
      bad++;
      $display("FAIL single_collision: collision=%b expected 0", collision);
    end
  endtask

  task automatic test_collision();
    txn_t t1, t2;
    t1 = '{path: 1, data: 32'h1111_1111, rd: 5'd1, we: 1'b1};
    t2 = '{path: 2, data: 32'h2222_2222, rd: 5'd2, we: 1'b0};
    @(posedge clk); #1 begin drive_req(t1); drive_req(t2); end
    serve(t1, 2, "coll_first");
    total++;
    if (collision !== 1'b1) begin
      bad++;
      $display("FAIL collision_flag: collision=%b expected 1", collision);
    end
    total++;
    if (req_out !== 1'b0) begin
      bad++;
      $display("FAIL coll_gap: req_out=%b expected 0 as ack_out_1 falls", req_out);
    end
    serve(t2, 0, "coll_second");
  endtask

  task automatic test_ack_hold();
    txn_t t;
    t = '{path: 1, data: W'($urandom()), rd: 5'($urandom_range(0, 31)), we: 1'b1};
    @(posedge clk); #1 drive_req(t);
    serve(t, 10, "ack_hold");
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bit ok;
    t = '{path: 2, data: 32'hCAFE_0042, rd: 5'd19, we: 1'b1};
    @(posedge clk); #1 drive_req(t);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_out === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rst_mid_send: req_out=%b expected 1 before reset", req_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_out, ack_vec, data_out, rd_out, we_out, collision} !== '0) begin
      bad++;
      $display("FAIL rst_mid_clear: req=%b ack=%b data=%h rd=%0d we=%b coll=%b expected all 0",
               req_out, ack_vec, data_out, rd_out, we_out, collision);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (req_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_early: req_out=%b expected 0 two edges after release", req_out);
    end
    @(negedge clk);
    total++;
    if (req_out !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_resume: req_out=%b expected 1 three edges after release", req_out);
    end
    serve(t, 1, "rst_mid");
  endtask

  task automatic test_back_to_back();
    txn_t ls, bj;
    ls = '{path: 2, data: 32'h1234_5678, rd: 5'd5, we: 1'b1};
    bj = '{path: 1, data: 32'hDEAD_BEEF, rd: 5'd31, we: 1'b0};
    @(posedge clk); #1 drive_req(ls);
    serve(ls, 0, "b2b_ls");
    @(posedge clk); #1 drive_req(bj);
    serve(bj, 0, "b2b_bj");
  endtask

  // Random subsets of producers raise together; the model predicts the
  // service order from the pending set and the sticky collision flag.
  task automatic test_random();
    txn_t pend[$];
    txn_t t;
    logic [2:0] mask;
    logic coll_model;
    apply_reset();
    coll_model = 1'b0;
    for (int it = 0; it < 20; it++) begin
      mask = 3'($urandom_range(1, 7));
      pend.delete();
      for (int p = 1; p <= 3; p++) begin
        if (mask[p-1]) begin
          t = '{path: p, data: W'($urandom()), rd: 5'($urandom_range(0, 31)),
                we: 1'($urandom_range(0, 1))};
          pend.push_back(t);
        end
      end
      if ($countones(mask) >= 2) coll_model = 1'b1;
      @(posedge clk); #1;
      foreach (pend[i]) drive_req(pend[i]);
      while (pend.size() > 0) begin
        t = pend.pop_front();
        serve(t, $urandom_range(0, 4), $sformatf("rand%0d_p%0d", it, t.path));
      end
      total++;
      if (collision !== coll_model) begin
        bad++;
        $display("FAIL rand%0d collision: collision=%b expected %b", it, collision, coll_model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_ack_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
